// File: rtl/demux_mailbox_bank.sv
// Purpose: 1-to-16 demux into single-entry mailbox lanes, popped by index by a consumer.
// Latency: write visible on lane_full/out_bus 1 cycle after accept; pop data/pulses 1 cycle after rd_en.
// Backpressure: in_ready low when the addressed lane is full (unless popped that cycle) or clr is asserted.
module demux_mailbox_bank #(
    parameter int WIDTH = 32,
    parameter int LANES = 16,
    parameter int SEL_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   rd_en,
    input  logic [SEL_W-1:0]       rd_sel,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   rd_err,
    output logic [LANES-1:0]       lane_full,
    output logic [4:0]             count,
    output logic [WIDTH*LANES-1:0] out_bus
);

    logic [WIDTH-1:0] lane_q [LANES];
    logic [LANES-1:0] full_q, full_d;
    logic [4:0]       count_q, count_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             rd_err_q;

    logic             same_lane_pop;
    logic             wr_fire;
    logic             pop_ok;
    logic             pop_err;

    // A full lane becomes writable in the cycle it is being popped; clr blocks everything.
    assign same_lane_pop = rd_en && (rd_sel == in_sel);
    assign in_ready      = !clr && (!full_q[in_sel] || same_lane_pop);
    assign wr_fire       = in_valid && in_ready;
    assign pop_ok        = rd_en && !clr && full_q[rd_sel];
    assign pop_err       = rd_en && !clr && !full_q[rd_sel];

    // Next full flags: pop clears first so a same-lane write re-sets it; clr wins over both.
    always_comb begin
        full_d = full_q;
        if (pop_ok) begin
            full_d[rd_sel] = 1'b0;
        end
        if (wr_fire) begin
            full_d[in_sel] = 1'b1;
        end
        if (clr) begin
            full_d = '0;
        end
    end

    // Occupancy tracks accepted writes minus successful pops; pass-through nets to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (wr_fire && !pop_ok) begin
            count_d = count_q + 5'd1;
        end else if (pop_ok && !wr_fire) begin
            count_d = count_q - 5'd1;
        end
    end

    // Lane storage: only an accepted write changes a lane; pops and clr leave data in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else if (wr_fire) begin
            lane_q[in_sel] <= in_data;
        end
    end

    // Flags, count and pop result registers; rd_data captures the pre-write lane value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            full_q     <= full_d;
            count_q    <= count_d;
            rd_valid_q <= pop_ok;
            rd_err_q   <= pop_err;
            if (pop_ok) begin
                rd_data_q <= lane_q[rd_sel];
            end
        end
    end

    assign lane_full = full_q;
    assign count     = count_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;

    // Flat view of every lane for the downstream 16:1 select stage.
    for (genvar g = 0; g < LANES; g++) begin : g_bus
        assign out_bus[g*WIDTH +: WIDTH] = lane_q[g];
    end

endmodule

// File: tb/tb_demux_mailbox_bank.sv
module tb_demux_mailbox_bank;

    localparam int W = 32;
    localparam int L = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clr;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_sel;
    logic [W-1:0]   in_data;
    logic           rd_en;
    logic [3:0]     rd_sel;
    logic [W-1:0]   rd_data;
    logic           rd_valid;
    logic           rd_err;
    logic [L-1:0]   lane_full;
    logic [4:0]     count;
    logic [W*L-1:0] out_bus;

    always #5 clk = ~clk;

    demux_mailbox_bank #(.WIDTH(W), .LANES(L), .SEL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_err    (rd_err),
        .lane_full (lane_full),
        .count     (count),
        .out_bus   (out_bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [W-1:0] m_lane [L];
    logic [L-1:0] m_full;
    logic [W-1:0] m_rd;
    logic         m_rv;
    logic         m_re;
    logic [W-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W*L-1:0] model_bus();
        logic [W*L-1:0] b;
        for (int k = 0; k < L; k++) b[k*W +: W] = m_lane[k];
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < L; k++) m_lane[k] = '0;
        m_full = '0;
        m_rd   = '0;
        m_rv   = 1'b0;
        m_re   = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        logic [W-1:0] e;
        check_eq({tag, "_full"},  lane_full, m_full);
        check_eq({tag, "_count"}, count, $countones(m_full));
        check_eq({tag, "_bus"},   out_bus, model_bus());
        check_eq({tag, "_rv"},    rd_valid, m_rv);
        check_eq({tag, "_rerr"},  rd_err, m_re);
        check_eq({tag, "_rdata"}, rd_data, m_rd);
        if (rd_valid === 1'b1) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq({tag, "_sb"}, rd_data, e);
            end else begin
                check_eq({tag, "_sb_underflow"}, rd_valid, 1'b0);
            end
        end
    endtask

    // Drive one cycle of stimulus, update the model, clock, then check.
    task automatic step(input string tag, input logic iv, input logic [3:0] is, input logic [W-1:0] id,
                        input logic re, input logic [3:0] rs, input logic c);
        logic mr, wr, pop, err;
        in_valid = iv; in_sel = is; in_data = id;
        rd_en = re; rd_sel = rs; clr = c;
        #1;
        mr  = !c && (!m_full[is] || (re && rs == is));
        check_eq({tag, "_ready"}, in_ready, mr);
        wr  = iv && mr;
        pop = re && !c && m_full[rs];
        err = re && !c && !m_full[rs];
        if (pop) begin
            m_rd = m_lane[rs];
            exp_q.push_back(m_lane[rs]);
            m_full[rs] = 1'b0;
        end
        if (wr) begin
            m_lane[is] = id;
            m_full[is] = 1'b1;
        end
        if (c) m_full = '0;
        m_rv = pop;
        m_re = err;
        @(posedge clk);
        #1;
        in_valid = 1'b0; rd_en = 1'b0; clr = 1'b0;
        check_outputs(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_full"},  lane_full, '0);
        check_eq({tag, "_count"}, count, '0);
        check_eq({tag, "_bus"},   out_bus, '0);
        check_eq({tag, "_rv"},    rd_valid, '0);
        check_eq({tag, "_rerr"},  rd_err, '0);
        check_eq({tag, "_rdata"}, rd_data, '0);
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0;
        rd_en = 1'b0; rd_sel = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        @(posedge clk); #1;
        check_all_zero("rst_hold");
        rst_n = 1'b1;

        // Basic write then pop on lane 5
        step("wr5", 1'b1, 4'd5, 32'hAA, 1'b0, 4'd0, 1'b0);
        check_eq("wr5_full_exact", lane_full, 16'h0020);
        check_eq("wr5_lane", out_bus[191:160], 32'hAA);
        step("pop5", 1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0);
        check_eq("pop5_data", rd_data, 32'hAA);
        step("idle0", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);

        // Fill all lanes with k+1
        for (int k = 0; k < L; k++) step("fill", 1'b1, 4'(k), 32'(k + 1), 1'b0, 4'd0, 1'b0);
        check_eq("fill_count", count, 5'd16);
        check_eq("fill_full", lane_full, 16'hFFFF);
        for (int k = 0; k < L; k++) begin
            in_sel = 4'(k);
            #1 check_eq("full_noready", in_ready, 1'b0);
        end
        step("rej3", 1'b1, 4'd3, 32'h99, 1'b0, 4'd0, 1'b0);
        check_eq("rej3_lane", out_bus[3*W +: W], 32'd4);

        // Pass-through on lane 7
        step("pop7", 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b0);
        step("wr7", 1'b1, 4'd7, 32'h11, 1'b0, 4'd0, 1'b0);
        step("pt7", 1'b1, 4'd7, 32'h22, 1'b1, 4'd7, 1'b0);
        check_eq("pt7_rdata", rd_data, 32'h11);
        check_eq("pt7_lane", out_bus[7*W +: W], 32'h22);
        check_eq("pt7_count", count, 5'd16);

        // Empty pop of lane 9
        step("pop9", 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 1'b0);
        step("epop9", 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 1'b0);
        check_eq("epop9_err", rd_err, 1'b1);
        check_eq("epop9_rdata", rd_data, 32'd10);
        step("epop9_after", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0);

        // clr overrides a same-cycle write and pop
        step("clr0", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 3; k++) step("wr012", 1'b1, 4'(k), 32'hC0 + 32'(k), 1'b0, 4'd0, 1'b0);
        step("clr1", 1'b1, 4'd4, 32'hDEAD, 1'b1, 4'd0, 1'b1);
        check_eq("clr1_full", lane_full, 16'h0);
        check_eq("clr1_lane4", out_bus[4*W +: W], 32'd5);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rnd", 1'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom),
                 ($urandom_range(15) == 0));
        end

        // Async reset mid-operation, with a pop in flight
        step("wr2", 1'b1, 4'd2, 32'h1234, 1'b0, 4'd0, 1'b0);
        rd_en = 1'b1; rd_sel = 4'd2;
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        rd_en = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_all_zero("rst_mid_hold");
        rst_n = 1'b1;
        step("post_rst", 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b0);
        check_eq("post_rst_err", rd_err, 1'b1);

        check_eq("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_mailbox_bank.md
Name: demux_mailbox_bank

Overview:
- 1-to-16 demultiplexing counterpart to the ALU 16:1 result MUX: steers one 32-bit word into one of 16 lane registers selected by a 4-bit select.
- Each lane is a single-entry mailbox with a full flag. A producer writes through a valid/ready handshake; a consumer pops lanes by index.
- All lane contents are also exposed on a flat bus that feeds the 16:1 select stage.

Parameters:
WIDTH, 32, data width per lane
LANES, 16, number of lanes (fixed at 16 for this design)
SEL_W, 4, select width, log2(LANES)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of all full flags
in_valid  in  1  producer has a word
in_ready  out  1  lane addressed by in_sel can accept a word (combinational)
in_sel  in  SEL_W  destination lane
in_data  in  WIDTH  word to write
rd_en  in  1  consumer pop request
rd_sel  in  SEL_W  lane to pop
rd_data  out  WIDTH  popped word (registered)
rd_valid  out  1  rd_data valid, one-cycle pulse
rd_err  out  1  pop of an empty lane, one-cycle pulse
lane_full  out  LANES  per-lane full flags
count  out  5  number of full lanes, 0..16
out_bus  out  WIDTH*LANES  lane k at [k*WIDTH +: WIDTH]

Behaviour:
- Reset (async, rst_n=0):
  - All lane registers, lane_full, rd_data, rd_valid, rd_err and count go to 0 immediately and stay 0 while rst_n is low.
  - Reset mid-operation discards everything, including any pending pop.
- Storage: 16 x WIDTH registers plus lane_full[15:0]. out_bus is driven directly from the registers; there is no extra stage.
- in_ready (combinational):
  - in_ready = !clr && (!lane_full[in_sel] || (rd_en && rd_sel==in_sel)).
  - A full lane is therefore writable in the same cycle it is popped (pass-through).
- Write:
  - Occurs when in_valid && in_ready at a clock edge.
  - The next edge updates lane[in_sel] <= in_data and lane_full[in_sel] <= 1, so write latency is 1 cycle.
  - in_valid with in_ready=0 changes nothing; the producer must hold in_data and in_sel stable until accepted.
- Pop:
  - rd_en with lane_full[rd_sel]=1 at an edge gives rd_data <= lane[rd_sel] and rd_valid <= 1 on the next cycle.
  - lane_full[rd_sel] clears unless a write to the same lane is accepted in the same cycle. In that case rd_data gets the OLD word, the lane takes the new word, and the flag stays 1.
  - Lane register contents are not cleared by a pop; only the flag changes.
- Empty pop: rd_en with lane_full[rd_sel]=0 gives rd_valid=0, rd_err=1 for one cycle, and rd_data holds its previous value.
- Pulses: rd_valid and rd_err are 0 on every cycle without a qualifying pop; they are never both 1.
- Simultaneous events:
  - A write and a pop to different lanes both take effect.
  - A write to lane A and a pop of lane A behave as the pass-through case above.
- clr:
  - At the edge, all lane_full go to 0 and count goes to 0.
  - clr overrides any write or pop in the same cycle: no rd_valid and no rd_err.
  - Lane data is left unchanged, so out_bus keeps stale values.
- count: registered; count_next = count + accepted_write - successful_pop, with pass-through counted as net 0. Range 0..16, with no wrap possible.
- Boundaries:
  - When all 16 lanes are full, count=16 and in_ready=0 for every in_sel except the pass-through case.
  - in_sel and rd_sel cover all 16 codes; there are no illegal selects.

Test Plan:
- Reset then write in_data=0x0000_00AA to in_sel=5 -> next cycle lane_full=0x0020, count=1, out_bus[191:160]=0xAA; then rd_en, rd_sel=5 -> next cycle rd_valid=1, rd_data=0xAA, lane_full=0, count=0.
- Write lane k with value k+1 for k=0..15 -> count=16, lane_full=0xFFFF, in_ready=0 for every in_sel with rd_en=0; an additional write to lane 3 is not accepted and lane 3 stays 4.
- Lane 7 full with 0x11; same cycle rd_en, rd_sel=7 and write 0x22 to lane 7 -> in_ready=1, next cycle rd_data=0x11, rd_valid=1, lane 7=0x22, lane_full[7]=1, count unchanged.
- rd_en, rd_sel=9 with lane 9 empty -> rd_err=1 for one cycle, rd_valid=0, rd_data unchanged, count unchanged.
- Lanes 0,1,2 full; assert clr together with a write to lane 4 and a pop of lane 0 -> next cycle lane_full=0, count=0, no rd_valid/rd_err, lane 4 register unchanged.
- Write to lane 2, then drop rst_n low between clock edges -> all outputs 0 immediately; after release, lane_full=0 and a pop of lane 2 gives rd_err=1.
